// File: rtl/spi_cfg_master.sv
// spi_cfg_master
//   Round-robin register-write sequencer for the SPI configuration port of the
//   PWM/output-enable register file. Each accepted write becomes one 16-bit
//   SPI mode-0 frame, MSB first: {1'b1 (write), addr[6:0], data[7:0]}.
//
// Parameters
//   CLK_DIV   clk cycles per SCLK half-period (4..255)
//   CS_SETUP  clk cycles ncs low before the first SCLK rise phase (4..255)
//   CS_HOLD   clk cycles ncs low after the last SCLK fall (2..255)
//   CS_GAP    minimum clk cycles ncs high between frames (2..255)
//   MAX_ADDR  highest register address implemented by the peripheral
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/addr/data/ready      requester N write channel (N = 0, 1)
//   ncs, sclk, copi                 SPI pins (ncs active low, sclk idles low)
//   busy                            high whenever the sequencer is not idle
//   done, done_id                   completion pulse and requester index
//   err                             pulse with done: address out of range
//   skipped                         pulse with done: write suppressed as redundant
//
// Optional feature
//   SPI_CFG_SKIP_REDUNDANT_EN  keeps a shadow copy of every register and
//                              suppresses writes whose data matches it.
//                              Undefined: every legal write is framed and
//                              skipped stays 0.

module spi_cfg_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4,
   parameter int CS_GAP   = 4,
   parameter int MAX_ADDR = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [6:0] req0_addr,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [6:0] req1_addr,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       ncs,
   output logic       sclk,
   output logic       copi,
   output logic       busy,
   output logic       done,
   output logic       done_id,
   output logic       err,
   output logic       skipped
);

   localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
   localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);
   localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_t;

   state_t      state;
   logic        last_grant;
   logic [7:0]  cnt;
   logic [4:0]  bit_cnt;
   logic [14:0] shreg;      // bits 14:0 of the frame; bit 15 goes out first
   logic        cur_id;

   logic        grant0;
   logic        grant1;
   logic        hs;
   logic        sel_id;
   logic [6:0]  sel_addr;
   logic [7:0]  sel_data;
   logic        addr_bad;

`ifdef SPI_CFG_SKIP_REDUNDANT_EN
   localparam int unsigned NUM_SHADOW = MAX_ADDR + 1;
   logic [6:0]  cur_addr;
   logic [7:0]  cur_data;
   logic [7:0]  shadow [NUM_SHADOW];
   logic        shadow_hit;
`endif

   // A lone requester always wins; on contention the one not granted last wins.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant);
      grant1 = req1_valid & (~req0_valid | ~last_grant);
   end

   assign req0_ready = (state == S_IDLE) & grant0;
   assign req1_ready = (state == S_IDLE) & grant1;
   assign busy       = (state != S_IDLE);

   always_comb begin
      hs       = req0_ready | req1_ready;
      sel_id   = req1_ready;
      sel_addr = req1_ready ? req1_addr : req0_addr;
      sel_data = req1_ready ? req1_data : req0_data;
      addr_bad = (sel_addr > MAX_ADDR_L);
   end

`ifdef SPI_CFG_SKIP_REDUNDANT_EN
   always_comb begin
      shadow_hit = 1'b0;
      for (int unsigned i = 0; i < NUM_SHADOW; i++) begin
         if ((sel_addr == 7'(i)) && (shadow[i] == sel_data)) begin
            shadow_hit = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         cnt        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         cur_id     <= 1'b0;
         ncs        <= 1'b1;
         sclk       <= 1'b0;
         copi       <= 1'b0;
         done       <= 1'b0;
         done_id    <= 1'b0;
         err        <= 1'b0;
         skipped    <= 1'b0;
`ifdef SPI_CFG_SKIP_REDUNDANT_EN
         cur_addr   <= '0;
         cur_data   <= '0;
         for (int unsigned i = 0; i < NUM_SHADOW; i++) begin
            shadow[i] <= '0;
         end
`endif
      end else begin
         done    <= 1'b0;
         err     <= 1'b0;
         skipped <= 1'b0;
         case (state)
            S_IDLE: begin
               if (hs) begin
                  last_grant <= sel_id;
                  cur_id     <= sel_id;
                  cnt        <= '0;
                  bit_cnt    <= '0;
`ifdef SPI_CFG_SKIP_REDUNDANT_EN
                  cur_addr   <= sel_addr;
                  cur_data   <= sel_data;
`endif
                  if (addr_bad) begin
                     state   <= S_GAP;
                     done    <= 1'b1;
                     err     <= 1'b1;
                     done_id <= sel_id;
`ifdef SPI_CFG_SKIP_REDUNDANT_EN
                  end else if (shadow_hit) begin
                     state   <= S_GAP;
                     done    <= 1'b1;
                     skipped <= 1'b1;
                     done_id <= sel_id;
`endif
                  end else begin
                     state <= S_SETUP;
                     ncs   <= 1'b0;
                     sclk  <= 1'b0;
                     copi  <= 1'b1;
                     shreg <= {sel_addr, sel_data};
                  end
               end
            end

            S_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt   <= '0;
                  state <= S_SHIFT;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end

            // copi only moves on the high->low transition, so it is stable for
            // a full low phase before and a full high phase after every rise.
            S_SHIFT: begin
               if (cnt == DIV_LAST) begin
                  cnt <= '0;
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else begin
                     sclk <= 1'b0;
                     if (bit_cnt == 5'd15) begin
                        state <= S_HOLD;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                        copi    <= shreg[14];
                        shreg   <= {shreg[13:0], 1'b0};
                     end
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end

            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt     <= '0;
                  state   <= S_GAP;
                  ncs     <= 1'b1;
                  copi    <= 1'b0;
                  done    <= 1'b1;
                  done_id <= cur_id;
`ifdef SPI_CFG_SKIP_REDUNDANT_EN
                  for (int unsigned i = 0; i < NUM_SHADOW; i++) begin
                     if (cur_addr == 7'(i)) begin
                        shadow[i] <= cur_data;
                     end
                  end
`endif
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end

            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cfg_master.sv
// tb_spi_cfg_master
//   Directed bench for spi_cfg_master at default parameters. A pin monitor
//   rebuilds each SPI frame from sclk/copi/ncs and records completions; one
//   task per scenario drives requests and compares against hand-derived values.

module tb_spi_cfg_master;

   localparam int CLK_DIV  = 4;
   localparam int CS_SETUP = 4;
   localparam int CS_HOLD  = 4;
   localparam int CS_GAP   = 4;
   localparam int MAX_ADDR = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req0_valid = 1'b0;
   logic [6:0] req0_addr = '0;
   logic [7:0] req0_data = '0;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [6:0] req1_addr = '0;
   logic [7:0] req1_data = '0;
   logic       req1_ready;
   logic       ncs, sclk, copi, busy, done, done_id, err, skipped;

   spi_cfg_master #(
      .CLK_DIV (CLK_DIV),
      .CS_SETUP(CS_SETUP),
      .CS_HOLD (CS_HOLD),
      .CS_GAP  (CS_GAP),
      .MAX_ADDR(MAX_ADDR)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_valid(req0_valid),
      .req0_addr (req0_addr),
      .req0_data (req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid),
      .req1_addr (req1_addr),
      .req1_data (req1_data),
      .req1_ready(req1_ready),
      .ncs       (ncs),
      .sclk      (sclk),
      .copi      (copi),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id),
      .err       (err),
      .skipped   (skipped)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   // ---------------- pin monitor (sampled on the falling clk edge) ----------
   int          done_cnt = 0;
   int          d_cyc = 0;
   logic        d_id = 1'b0, d_err = 1'b0, d_skip = 1'b0;
   int          frames = 0;
   logic [15:0] mon_shift = '0;
   int          mon_bits = 0;
   int          low_run = 0;
   logic [15:0] last_frame = '0;
   int          last_bits = 0;
   int          last_low = 0;
   logic [15:0] frame_log[$];
   int          hi_len = 0, low_len = 0;
   logic        seen_fall = 1'b0;
   int          phase_bad = 0, copi_bad = 0, rise_bad = 0;
   logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         d_cyc  = cyc;
         d_id   = done_id;
         d_err  = err;
         d_skip = skipped;
      end
      if (ncs === 1'b0) begin
         if (prev_ncs) begin
            mon_bits  = 0;
            mon_shift = '0;
            low_run   = 0;
            seen_fall = 1'b0;
         end
         low_run++;
      end
      if (ncs === 1'b1 && !prev_ncs) begin
         frames++;
         last_frame = mon_shift;
         last_bits  = mon_bits;
         last_low   = low_run;
         frame_log.push_back(mon_shift);
      end
      if (sclk === 1'b1 && !prev_sclk) begin
         if (ncs !== 1'b0) rise_bad++;
         if (seen_fall && low_len != CLK_DIV) phase_bad++;
         mon_shift = {mon_shift[14:0], copi};
         mon_bits++;
         hi_len = 0;
      end
      if (sclk === 1'b1) hi_len++;
      if (sclk === 1'b0 && prev_sclk) begin
         if (hi_len != CLK_DIV) phase_bad++;
         seen_fall = 1'b1;
         low_len   = 0;
      end
      if (sclk === 1'b0) low_len++;
      if (sclk === 1'b1 && prev_sclk && copi !== prev_copi) copi_bad++;
      prev_ncs  = ncs;
      prev_sclk = sclk;
      prev_copi = copi;
   end

   // ---------------- stimulus helpers ----------------------------------------
   task automatic reset_dut();
      @(negedge clk);
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Presents one request and returns the cycle in which valid&ready held.
   task automatic do_req(input int id, input logic [6:0] a, input logic [7:0] d, output int hs);
      hs = -1;
      @(negedge clk);
      if (id == 0) begin
         req0_addr = a; req0_data = d; req0_valid = 1'b1;
      end else begin
         req1_addr = a; req1_data = d; req1_valid = 1'b1;
      end
      for (int i = 0; i < 400; i++) begin
         #1;
         if ((id == 0) ? req0_ready : req1_ready) begin
            hs = cyc;
            break;
         end
         @(negedge clk);
      end
      total++;
      if (hs < 0) begin
         bad++;
         $display("FAIL handshake_timeout: req%0d never ready within 400 cycles", id);
      end
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_done(input int start, output bit got);
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #2;
         if (done_cnt != start) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- scenarios -----------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      repeat (2) @(negedge clk);
      total++; if (ncs !== 1'b1)  begin bad++; $display("FAIL rst_ncs: got %b want 1", ncs); end
      total++; if (sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk: got %b want 0", sclk); end
      total++; if (copi !== 1'b0) begin bad++; $display("FAIL rst_copi: got %b want 0", copi); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if ({done, err, skipped} !== 3'b000) begin bad++; $display("FAIL rst_pulses: got %b want 000", {done, err, skipped}); end
      total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready}); end
      rst_n = 1'b1;
      @(negedge clk);
      req1_valid = 1'b1;
      #1;
      total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL lone_req1_ready: got %b want 01", {req0_ready, req1_ready}); end
      req0_valid = 1'b1;
      #1;
      total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL first_contest_ready: got %b want 10", {req0_ready, req1_ready}); end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_single_write();
      int hs, dc0, f0, pb0, cb0, rb0;
      bit got;
      reset_dut();
      dc0 = done_cnt; f0 = frames; pb0 = phase_bad; cb0 = copi_bad; rb0 = rise_bad;
      do_req(0, 7'h04, 8'hA5, hs);
      wait_done(dc0, got);
      total++; if (!got) begin bad++; $display("FAIL single_done_seen: got none want pulse"); end
      total++; if (d_cyc != hs + 137) begin bad++; $display("FAIL single_done_time: got %0d want %0d", d_cyc - hs, 137); end
      total++; if (d_id !== 1'b0) begin bad++; $display("FAIL single_done_id: got %b want 0", d_id); end
      total++; if (d_err !== 1'b0 || d_skip !== 1'b0) begin bad++; $display("FAIL single_flags: got err=%b skip=%b want 0 0", d_err, d_skip); end
      total++; if (frames != f0 + 1) begin bad++; $display("FAIL single_frames: got %0d want %0d", frames - f0, 1); end
      total++; if (last_frame !== 16'h84A5) begin bad++; $display("FAIL single_frame: got %h want 84a5", last_frame); end
      total++; if (last_bits != 16) begin bad++; $display("FAIL single_rises: got %0d want 16", last_bits); end
      total++; if (last_low != 136) begin bad++; $display("FAIL single_ncs_low: got %0d want 136", last_low); end
      total++; if (phase_bad != pb0) begin bad++; $display("FAIL single_phase_len: got %0d bad phases want 0", phase_bad - pb0); end
      total++; if (copi_bad != cb0) begin bad++; $display("FAIL single_copi_stable: got %0d changes want 0", copi_bad - cb0); end
      total++; if (rise_bad != rb0) begin bad++; $display("FAIL single_rise_ncs: got %0d rises with ncs high want 0", rise_bad - rb0); end
   endtask

   task automatic test_clk_div();
      int hs, dc0, pb0, cb0;
      bit got;
      dc0 = done_cnt; pb0 = phase_bad; cb0 = copi_bad;
      do_req(1, 7'h03, 8'h5C, hs);
      wait_done(dc0, got);
      total++; if (last_frame !== 16'h835C) begin bad++; $display("FAIL clkdiv_frame: got %h want 835c", last_frame); end
      total++; if (phase_bad != pb0) begin bad++; $display("FAIL clkdiv_phase_len: got %0d bad phases want 0", phase_bad - pb0); end
      total++; if (copi_bad != cb0) begin bad++; $display("FAIL clkdiv_copi_stable: got %0d changes want 0", copi_bad - cb0); end
      total++; if (d_id !== 1'b1) begin bad++; $display("FAIL clkdiv_done_id: got %b want 1", d_id); end
   endtask

   task automatic test_back_to_back();
      int order[4];
      int hcyc[4];
      int n, dc0, q0, f0;
      logic [15:0] exp_f[4];
      int exp_gap[3];
      exp_f = '{16'h8111, 16'h8322, 16'h8111, 16'h8322};
`ifdef SPI_CFG_SKIP_REDUNDANT_EN
      exp_gap = '{141, 141, 5};
`else
      exp_gap = '{141, 141, 141};
`endif
      reset_dut();
      dc0 = done_cnt; q0 = frame_log.size(); f0 = frames; n = 0;
      @(negedge clk);
      req0_addr = 7'h01; req0_data = 8'h11; req0_valid = 1'b1;
      req1_addr = 7'h03; req1_data = 8'h22; req1_valid = 1'b1;
      for (int i = 0; i < 800 && n < 4; i++) begin
         #1;
         if (req0_ready && req1_ready) begin
            total++; bad++;
            $display("FAIL b2b_one_ready: got both ready want one");
         end
         if (req0_ready) begin order[n] = 0; hcyc[n] = cyc; n++; end
         else if (req1_ready) begin order[n] = 1; hcyc[n] = cyc; n++; end
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      total++;
      if (n != 4) begin
         bad++;
         $display("FAIL b2b_handshakes: got %0d want 4", n);
      end else begin
         for (int k = 0; k < 4; k++) begin
            total++;
            if (order[k] != k % 2) begin bad++; $display("FAIL b2b_grant%0d: got %0d want %0d", k, order[k], k % 2); end
         end
         for (int k = 0; k < 3; k++) begin
            total++;
            if (hcyc[k + 1] - hcyc[k] != exp_gap[k]) begin bad++; $display("FAIL b2b_interval%0d: got %0d want %0d", k, hcyc[k + 1] - hcyc[k], exp_gap[k]); end
         end
      end
      for (int i = 0; i < 400 && done_cnt < dc0 + 4; i++) @(negedge clk);
      #2;
      total++; if (done_cnt != dc0 + 4) begin bad++; $display("FAIL b2b_done_count: got %0d want 4", done_cnt - dc0); end
`ifdef SPI_CFG_SKIP_REDUNDANT_EN
      total++; if (frames != f0 + 2) begin bad++; $display("FAIL b2b_frames: got %0d want 2", frames - f0); end
      total++; if (frame_log.size() < q0 + 2 || frame_log[q0] !== exp_f[0] || frame_log[q0 + 1] !== exp_f[1]) begin
         bad++; $display("FAIL b2b_frame_data: first two frames differ from 8111 8322");
      end
`else
      total++; if (frames != f0 + 4) begin bad++; $display("FAIL b2b_frames: got %0d want 4", frames - f0); end
      else begin
         for (int k = 0; k < 4; k++) begin
            total++;
            if (frame_log[q0 + k] !== exp_f[k]) begin bad++; $display("FAIL b2b_frame%0d: got %h want %h", k, frame_log[q0 + k], exp_f[k]); end
         end
      end
`endif
   endtask

   task automatic test_reject();
      int hs1, hs2, dc0, f0;
      bit got;
      reset_dut();
      dc0 = done_cnt; f0 = frames;
      do_req(1, 7'h05, 8'h77, hs1);
      wait_done(dc0, got);
      total++; if (!got || d_cyc != hs1 + 1) begin bad++; $display("FAIL rej_done_time: got %0d want 1", d_cyc - hs1); end
      total++; if (d_err !== 1'b1) begin bad++; $display("FAIL rej_err: got %b want 1", d_err); end
      total++; if (d_id !== 1'b1) begin bad++; $display("FAIL rej_done_id: got %b want 1", d_id); end
      total++; if (frames != f0) begin bad++; $display("FAIL rej_no_frame: got %0d frames want 0", frames - f0); end
      dc0 = done_cnt;
      do_req(1, 7'h02, 8'h5A, hs2);
      total++; if (hs2 - hs1 != 5) begin bad++; $display("FAIL rej_next_hs: got %0d want 5", hs2 - hs1); end
      wait_done(dc0, got);
      total++; if (!got || d_cyc != hs2 + 137) begin bad++; $display("FAIL rej_legal_done_time: got %0d want 137", d_cyc - hs2); end
      total++; if (d_err !== 1'b0 || d_id !== 1'b1) begin bad++; $display("FAIL rej_legal_flags: got err=%b id=%b want 0 1", d_err, d_id); end
      total++; if (last_frame !== 16'h825A) begin bad++; $display("FAIL rej_legal_frame: got %h want 825a", last_frame); end
   endtask

   task automatic test_reset_mid_frame();
      int hs, dc0, hit;
      bit got;
      reset_dut();
      dc0 = done_cnt; hit = 0;
      do_req(0, 7'h03, 8'hC3, hs);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #2;
         if (ncs === 1'b0 && mon_bits == 7) begin hit = 1; break; end
      end
      total++; if (hit == 0) begin bad++; $display("FAIL mid_reach_bit7: got no bit7 want bit7 within 300 cycles"); end
      rst_n = 1'b0;
      #1;
      total++; if (ncs !== 1'b1 || sclk !== 1'b0) begin bad++; $display("FAIL mid_async_pins: got ncs=%b sclk=%b want 1 0", ncs, sclk); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_async_busy: got %b want 0", busy); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #2;
      total++; if (done_cnt != dc0) begin bad++; $display("FAIL mid_no_done: got %0d dones want 0", done_cnt - dc0); end
      do_req(1, 7'h00, 8'h3C, hs);
      wait_done(dc0, got);
      total++; if (!got || last_frame !== 16'h803C || last_bits != 16) begin
         bad++; $display("FAIL mid_recovery_frame: got %h/%0d bits want 803c/16", last_frame, last_bits);
      end
   endtask

   task automatic test_skip();
      int hs, dc0, f0;
      bit got;
      reset_dut();
      dc0 = done_cnt; f0 = frames;
      do_req(0, 7'h02, 8'h00, hs);
      wait_done(dc0, got);
`ifdef SPI_CFG_SKIP_REDUNDANT_EN
      total++; if (!got || d_skip !== 1'b1 || d_cyc != hs + 1) begin bad++; $display("FAIL skip_zero: got skip=%b dt=%0d want 1 1", d_skip, d_cyc - hs); end
      total++; if (frames != f0) begin bad++; $display("FAIL skip_zero_frame: got %0d frames want 0", frames - f0); end
`else
      total++; if (!got || d_skip !== 1'b0) begin bad++; $display("FAIL skip_zero: got skip=%b want 0", d_skip); end
      total++; if (frames != f0 + 1 || last_frame !== 16'h8200) begin bad++; $display("FAIL skip_zero_frame: got %h want 8200", last_frame); end
`endif
      dc0 = done_cnt; f0 = frames;
      do_req(0, 7'h02, 8'h3C, hs);
      wait_done(dc0, got);
      total++; if (!got || d_skip !== 1'b0 || frames != f0 + 1 || last_frame !== 16'h823C) begin
         bad++; $display("FAIL skip_new_data: got skip=%b frame=%h want 0 823c", d_skip, last_frame);
      end
      dc0 = done_cnt; f0 = frames;
      do_req(0, 7'h02, 8'h3C, hs);
      wait_done(dc0, got);
`ifdef SPI_CFG_SKIP_REDUNDANT_EN
      total++; if (!got || d_skip !== 1'b1 || frames != f0) begin bad++; $display("FAIL skip_repeat: got skip=%b frames=%0d want 1 0", d_skip, frames - f0); end
`else
      total++; if (!got || d_skip !== 1'b0 || frames != f0 + 1) begin bad++; $display("FAIL skip_repeat: got skip=%b frames=%0d want 0 1", d_skip, frames - f0); end
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      test_reset();
      test_single_write();
      test_clk_div();
      test_back_to_back();
      test_reject();
      test_reset_mid_frame();
      test_skip();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
